vga_frame_reader: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 55 +++++
 rtl/vga_timing_gen.sv | 52 +++++
 rtl/vga_frame_reader.sv | 158 +++++++++++++++
 tb/tb_vga_frame_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, derived totals and sync
// windows, RGB444 field positions and the pipeline flag bundle used by the reader.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;
    localparam int unsigned DEF_PXL_WIDTH = 12;

    localparam int unsigned CNT_W = 10;

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
        return act + fp;
    endfunction

    function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync);
        return act + fp + sync - 1;
    endfunction

    localparam int unsigned H_TOTAL      = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned V_TOTAL      = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int unsigned H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
    localparam int unsigned V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int unsigned V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

    localparam int unsigned R_HI = 11;
    localparam int unsigned R_LO = 8;
    localparam int unsigned G_HI = 7;
    localparam int unsigned G_LO = 4;
    localparam int unsigned B_HI = 3;
    localparam int unsigned B_LO = 0;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic frame_start;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                    frame_start: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with combinational active, sync and frame-origin flags.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             n_reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             frame_first
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_n     = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        vsync_n     = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        frame_first = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame-buffer reader: issues BRAM reads per active pixel and aligns returned
// RGB444 data with sync at the pins. Optional colour-bar source under VGA_TEST_PATTERN_EN.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned BRAM_LAT  = 1,
    parameter int unsigned PXL_WIDTH = DEF_PXL_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_n_reset,
    input  logic                 i_pattern_sel,
    output logic [CNT_W-1:0]     o_rd_h_addr,
    output logic [CNT_W-1:0]     o_rd_v_addr,
    output logic                 o_rd_en,
    input  logic [PXL_WIDTH-1:0] i_rd_data,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic [3:0]           o_vga_r,
    output logic [3:0]           o_vga_g,
    output logic [3:0]           o_vga_b,
    output logic                 o_frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hsync_n;
    logic             vsync_n;
    logic             frame_first;
    logic             rd_issue;
    pipe_t            stage_in;
    pipe_t            dly [BRAM_LAT];
    pipe_t            tail;
    logic [11:0]      pix;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (i_clk),
        .n_reset     (i_n_reset),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_first (frame_first)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] pat_color;
    logic [11:0] pat_dly     [BRAM_LAT];
    logic        pat_sel_dly [BRAM_LAT];

    assign rd_issue  = active && !i_pattern_sel;
    // 128-px bars straight from the counter MSBs avoid a divide-by-80
    assign pat_color = {{4{h_cnt[9]}}, {4{h_cnt[8]}}, {4{h_cnt[7]}}};

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            for (int i = 0; i < int'(BRAM_LAT); i++) begin
                pat_dly[i]     <= '0;
                pat_sel_dly[i] <= 1'b0;
            end
        end else begin
            pat_dly[0]     <= pat_color;
            pat_sel_dly[0] <= i_pattern_sel;
            for (int i = 1; i < int'(BRAM_LAT); i++) begin
                pat_dly[i]     <= pat_dly[i-1];
                pat_sel_dly[i] <= pat_sel_dly[i-1];
            end
        end
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = i_pattern_sel;
    assign rd_issue           = active;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            o_rd_en     <= 1'b0;
            o_rd_h_addr <= '0;
            o_rd_v_addr <= '0;
        end else begin
            o_rd_en     <= rd_issue;
            o_rd_h_addr <= active ? h_cnt : '0;
            o_rd_v_addr <= active ? v_cnt : '0;
        end
    end

    always_comb begin
        stage_in             = PIPE_IDLE;
        stage_in.active      = active;
        stage_in.hsync_n     = hsync_n;
        stage_in.vsync_n     = vsync_n;
        stage_in.frame_start = frame_first;
    end

    // Flags ride alongside the BRAM read so sync and colour leave on the same edge
    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            for (int i = 0; i < int'(BRAM_LAT); i++) begin
                dly[i] <= PIPE_IDLE;
            end
        end else begin
            dly[0] <= stage_in;
            for (int i = 1; i < int'(BRAM_LAT); i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tail = dly[BRAM_LAT-1];

    always_comb begin
        pix = i_rd_data[R_HI:B_LO];
`ifdef VGA_TEST_PATTERN_EN
        if (pat_sel_dly[BRAM_LAT-1]) begin
            pix = pat_dly[BRAM_LAT-1];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_vga_r       <= 4'h0;
            o_vga_g       <= 4'h0;
            o_vga_b       <= 4'h0;
            o_frame_start <= 1'b0;
        end else begin
            o_hsync       <= tail.hsync_n;
            o_vsync       <= tail.vsync_n;
            o_vga_r       <= tail.active ? pix[R_HI:R_LO] : 4'h0;
            o_vga_g       <= tail.active ? pix[G_HI:G_LO] : 4'h0;
            o_vga_b       <= tail.active ? pix[B_HI:B_LO] : 4'h0;
            o_frame_start <= tail.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance plus three reduced-geometry instances
// (BRAM_LAT 1..3), each checked against a closed-form timing model and a pixel scoreboard.
module tb_vga_frame_reader;

    localparam int N = 4;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_BUILD = 1'b1;
`else
    localparam bit PAT_BUILD = 1'b0;
`endif

    logic clk         = 1'b0;
    logic n_reset     = 1'b0;
    logic pattern_sel = 1'b0;

    always #5 clk = ~clk;

    logic [9:0]  rd_h    [N];
    logic [9:0]  rd_v    [N];
    logic        rd_en   [N];
    logic [11:0] rd_data [N];
    logic        hs      [N];
    logic        vs      [N];
    logic        fs      [N];
    logic [3:0]  vr      [N];
    logic [3:0]  vg      [N];
    logic [3:0]  vb      [N];

    int checks = 0;
    int passes = 0;
    int t0     = 0;
    bit dir_on = 1'b0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h",
                     name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gi
        localparam bit FULL = (g == 0);
        localparam int LAT  = FULL ? 1 : g;
        localparam int HA   = FULL ? 640 : 16;
        localparam int HF   = FULL ? 16 : 2;
        localparam int HS   = FULL ? 96 : 4;
        localparam int HB   = FULL ? 48 : 3;
        localparam int VA   = FULL ? 480 : 6;
        localparam int VF   = FULL ? 10 : 1;
        localparam int VS   = 2;
        localparam int VB   = FULL ? 33 : 1;
        localparam int HT   = HA + HF + HS + HB;
        localparam int VT   = VA + VF + VS + VB;

        vga_frame_reader #(
            .H_ACTIVE  (HA),
            .H_FP      (HF),
            .H_SYNC    (HS),
            .H_BP      (HB),
            .V_ACTIVE  (VA),
            .V_FP      (VF),
            .V_SYNC    (VS),
            .V_BP      (VB),
            .BRAM_LAT  (LAT),
            .PXL_WIDTH (12)
        ) dut (
            .i_clk         (clk),
            .i_n_reset     (n_reset),
            .i_pattern_sel (pattern_sel),
            .o_rd_h_addr   (rd_h[g]),
            .o_rd_v_addr   (rd_v[g]),
            .o_rd_en       (rd_en[g]),
            .i_rd_data     (rd_data[g]),
            .o_hsync       (hs[g]),
            .o_vsync       (vs[g]),
            .o_vga_r       (vr[g]),
            .o_vga_g       (vg[g]),
            .o_vga_b       (vb[g]),
            .o_frame_start (fs[g])
        );

        // BRAM model: data for an address is sampled by the reader LAT edges after issue
        logic [19:0] a0, a1, a2, a_sel;
        assign a0 = {rd_h[g], rd_v[g]};
        always @(posedge clk) begin
            a1 <= a0;
            a2 <= a1;
        end
        assign a_sel      = (LAT == 1) ? a0 : ((LAT == 2) ? a1 : a2);
        assign rd_data[g] = {a_sel[13:10], a_sel[3:0], 4'hA};

        int          cyc   = 0;
        bit          armed = 1'b0;
        logic [11:0] exp_q [$];

        always @(posedge clk) begin
            if (!n_reset) begin
                cyc   <= 0;
                armed <= 1'b1;
                exp_q.delete();
            end else begin
                cyc <= cyc + 1;
            end
        end

        // Timing model: reads reflect counter position cyc-1, pins position cyc-LAT-1
        always @(negedge clk) begin
            int          p, ph, pv;
            bit          pat, exp_act, exp_rd;
            logic [9:0]  hv;
            logic [11:0] rgb, pat_rgb;
            if (armed) begin
                pat     = PAT_BUILD && pattern_sel;
                p       = cyc - 1;
                ph      = (p >= 0) ? p % HT : 0;
                pv      = (p >= 0) ? (p / HT) % VT : 0;
                exp_act = (p >= 0) && (ph < HA) && (pv < VA);
                exp_rd  = exp_act && !pat;
                check("rd_en", g, int'(rd_en[g]), int'(exp_rd));
                check("rd_h_addr", g, int'(rd_h[g]), exp_act ? ph : 0);
                check("rd_v_addr", g, int'(rd_v[g]), exp_act ? pv : 0);
                if (exp_rd) exp_q.push_back({ph[3:0], pv[3:0], 4'hA});

                p       = cyc - LAT - 1;
                ph      = (p >= 0) ? p % HT : 0;
                pv      = (p >= 0) ? (p / HT) % VT : 0;
                exp_act = (p >= 0) && (ph < HA) && (pv < VA);
                check("hsync", g, int'(hs[g]),
                      int'(!((p >= 0) && (ph >= HA + HF) && (ph < HA + HF + HS))));
                check("vsync", g, int'(vs[g]),
                      int'(!((p >= 0) && (pv >= VA + VF) && (pv < VA + VF + VS))));
                check("frame_start", g, int'(fs[g]), int'((p >= 0) && (ph == 0) && (pv == 0)));
                rgb     = {vr[g], vg[g], vb[g]};
                hv      = ph[9:0];
                pat_rgb = {{4{hv[9]}}, {4{hv[8]}}, {4{hv[7]}}};
                if (!exp_act)  check("blank_rgb", g, int'(rgb), 0);
                else if (pat)  check("pattern_rgb", g, int'(rgb), int'(pat_rgb));
                else           check("pixel_present", g, int'(rgb != 12'h0), 1);
            end
        end

        // Monitor: every pixel presented at the pins is matched against the oldest issued read
        always @(negedge clk) begin
            logic [11:0] got, want;
            got = {vr[g], vg[g], vb[g]};
            if (armed && !(PAT_BUILD && pattern_sel) && got != 12'h0) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
                check("pixel_rgb", g, int'(got), int'(want));
            end
        end
    end

    typedef struct {
        int t;
        int en;
        int h;
        int v;
        int hsy;
        int fst;
    } vec_t;

    vec_t vecs [10];

    always @(posedge clk) t0 <= n_reset ? t0 + 1 : 0;

    // Hand-derived points on the full-size instance, cycles counted from reset release
    always @(negedge clk) begin
        if (dir_on) begin
            foreach (vecs[i]) begin
                if (vecs[i].t == t0) begin
                    check("vec_rd_en", 0, int'(rd_en[0]), vecs[i].en);
                    check("vec_rd_h", 0, int'(rd_h[0]), vecs[i].h);
                    check("vec_rd_v", 0, int'(rd_v[0]), vecs[i].v);
                    check("vec_hsync", 0, int'(hs[0]), vecs[i].hsy);
                    check("vec_frame_start", 0, int'(fs[0]), vecs[i].fst);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{t: 1,   en: 1, h: 0,   v: 0, hsy: 1, fst: 0};
        vecs[1] = '{t: 2,   en: 1, h: 1,   v: 0, hsy: 1, fst: 1};
        vecs[2] = '{t: 640, en: 1, h: 639, v: 0, hsy: 1, fst: 0};
        vecs[3] = '{t: 641, en: 0, h: 0,   v: 0, hsy: 1, fst: 0};
        vecs[4] = '{t: 657, en: 0, h: 0,   v: 0, hsy: 1, fst: 0};
        vecs[5] = '{t: 658, en: 0, h: 0,   v: 0, hsy: 0, fst: 0};
        vecs[6] = '{t: 753, en: 0, h: 0,   v: 0, hsy: 0, fst: 0};
        vecs[7] = '{t: 754, en: 0, h: 0,   v: 0, hsy: 1, fst: 0};
        vecs[8] = '{t: 801, en: 1, h: 0,   v: 1, hsy: 1, fst: 0};
        vecs[9] = '{t: 802, en: 1, h: 1,   v: 1, hsy: 1, fst: 0};

        n_reset     = 1'b0;
        pattern_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        dir_on = 1'b1;
        repeat (1810) @(posedge clk);

        // Mid-frame reset held for three cycles, then a clean restart
        #1 n_reset = 1'b0;
        dir_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        repeat (700) @(posedge clk);

        // Pattern select: colour bars when built in, ignored otherwise
        #1 n_reset = 1'b0;
        pattern_sel = 1'b1;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        repeat (700) @(posedge clk);

        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
